// File: rtl/sweep_pkg.sv
// Shared types and defaults for the frequency-sweep sequencer.
package sweep_pkg;

  localparam int PHASE_W_DEF = 32;
  localparam int DATA_W_DEF  = 24;
  localparam int CNT_W_DEF   = 24;
  localparam int INIT_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_DWELL  = 3'd3,
    ST_REPORT = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/sweep_controller_peak_detector.sv
// Running maximum of |sample| with synchronous clear and sample enable.
// o_peak_next exposes the value the register takes on an enabled edge.
module peak_detector
  import sweep_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_peak_next
);

  // Unsigned magnitude; the most negative input maps to 2^(DATA_W-1) exactly.
  function automatic logic [DATA_W-1:0] abs_mag(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    if (v[DATA_W-1]) begin
      r = ~v + {{(DATA_W-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  logic [DATA_W-1:0] peak_q;
  logic [DATA_W-1:0] peak_d;
  logic [DATA_W-1:0] mag_s;

  // Magnitude, candidate maximum and register next-state.
  always_comb begin
    mag_s       = abs_mag(i_data);
    o_peak_next = (mag_s > peak_q) ? mag_s : peak_q;
    if (i_clr) begin
      peak_d = {DATA_W{1'b0}};
    end else if (i_en) begin
      peak_d = o_peak_next;
    end else begin
      peak_d = peak_q;
    end
  end

  // Peak register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      peak_q <= {DATA_W{1'b0}};
    end else begin
      peak_q <= peak_d;
    end
  end

endmodule

// File: rtl/sweep_controller.sv
// Frequency-sweep sequencer: steps the generator phase increment, settles,
// measures peak |filter output| per point and reports one result per point.
module sweep_controller
  import sweep_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic [PHASE_W-1:0]       i_start_step,
  input  logic [PHASE_W-1:0]       i_stop_step,
  input  logic [PHASE_W-1:0]       i_step_inc,
  input  logic [CNT_W-1:0]         i_settle_cycles,
  input  logic [CNT_W-1:0]         i_dwell_cycles,
  input  logic signed [DATA_W-1:0] i_filt_data,
  output logic [PHASE_W-1:0]       o_phase_step,
  output logic                     o_gen_rst,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_result_valid,
  output logic [PHASE_W-1:0]       o_result_step,
  output logic [DATA_W-1:0]        o_result_peak,
  output logic                     o_result_last
);

  localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   INIT_LAST  = CNT_W'(INIT_CYCLES - 1);
  localparam logic [PHASE_W-1:0] PHASE_ZERO = {PHASE_W{1'b0}};

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, settle_q, settle_d, dwell_q, dwell_d;
  logic [CNT_W-1:0]   cnt_inc_s, dwell_eff_s;
  logic [PHASE_W-1:0] stop_q, stop_d, inc_q, inc_d;
  logic [PHASE_W-1:0] phase_step_q, phase_step_d, result_step_q, result_step_d;
  logic [DATA_W-1:0]  result_peak_q, result_peak_d, peak_next_s;
  logic               gen_rst_q, gen_rst_d, busy_q, busy_d, done_q, done_d;
  logic               result_valid_q, result_valid_d, result_last_q, result_last_d;
  logic [PHASE_W:0]   next_step_s;
  logic               last_s, pk_clr_s, pk_en_s;

  peak_detector #(.DATA_W(DATA_W)) u_peak (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clr       (pk_clr_s),
    .i_en        (pk_en_s),
    .i_data      (i_filt_data),
    .o_peak_next (peak_next_s)
  );

  // Sequencer next-state and registered-output next values.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    settle_d       = settle_q;
    dwell_d        = dwell_q;
    stop_d         = stop_q;
    inc_d          = inc_q;
    phase_step_d   = phase_step_q;
    result_step_d  = result_step_q;
    result_peak_d  = result_peak_q;
    result_valid_d = 1'b0;
    result_last_d  = 1'b0;
    pk_clr_s       = 1'b0;
    pk_en_s        = 1'b0;

    cnt_inc_s   = cnt_q + CNT_ONE;
    dwell_eff_s = (dwell_q == CNT_ZERO) ? CNT_ONE : dwell_q;
    // Extra bit catches wrap past the top of the phase range.
    next_step_s = {1'b0, phase_step_q} + {1'b0, inc_q};
    last_s      = (inc_q == PHASE_ZERO) || (next_step_s > {1'b0, stop_q}) ||
                  next_step_s[PHASE_W];

    if (i_abort) begin
      state_d = ST_IDLE;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            stop_d       = i_stop_step;
            inc_d        = i_step_inc;
            settle_d     = i_settle_cycles;
            dwell_d      = i_dwell_cycles;
            phase_step_d = i_start_step;
            cnt_d        = CNT_ZERO;
            state_d      = ST_INIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_INIT: begin
          if (cnt_q == INIT_LAST) begin
            cnt_d = CNT_ZERO;
            if (settle_q == CNT_ZERO) begin
              state_d  = ST_DWELL;
              pk_clr_s = 1'b1;
            end else begin
              state_d = ST_SETTLE;
            end
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        ST_SETTLE: begin
          if (cnt_inc_s == settle_q) begin
            cnt_d    = CNT_ZERO;
            state_d  = ST_DWELL;
            pk_clr_s = 1'b1;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        ST_DWELL: begin
          pk_en_s = 1'b1;
          if (cnt_inc_s == dwell_eff_s) begin
            cnt_d          = CNT_ZERO;
            state_d        = ST_REPORT;
            result_valid_d = 1'b1;
            result_last_d  = last_s;
            result_step_d  = phase_step_q;
            result_peak_d  = peak_next_s;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        ST_REPORT: begin
          if (last_s) begin
            state_d = ST_DONE;
          end else begin
            phase_step_d = next_step_s[PHASE_W-1:0];
            if (settle_q == CNT_ZERO) begin
              state_d  = ST_DWELL;
              pk_clr_s = 1'b1;
            end else begin
              state_d = ST_SETTLE;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    gen_rst_d = (state_d == ST_INIT);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
  end

  // State, counters, shadow configuration and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= CNT_ZERO;
      settle_q       <= CNT_ZERO;
      dwell_q        <= CNT_ZERO;
      stop_q         <= PHASE_ZERO;
      inc_q          <= PHASE_ZERO;
      phase_step_q   <= PHASE_ZERO;
      result_step_q  <= PHASE_ZERO;
      result_peak_q  <= {DATA_W{1'b0}};
      result_valid_q <= 1'b0;
      result_last_q  <= 1'b0;
      gen_rst_q      <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      settle_q       <= settle_d;
      dwell_q        <= dwell_d;
      stop_q         <= stop_d;
      inc_q          <= inc_d;
      phase_step_q   <= phase_step_d;
      result_step_q  <= result_step_d;
      result_peak_q  <= result_peak_d;
      result_valid_q <= result_valid_d;
      result_last_q  <= result_last_d;
      gen_rst_q      <= gen_rst_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign o_phase_step   = phase_step_q;
  assign o_gen_rst      = gen_rst_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_result_valid = result_valid_q;
  assign o_result_step  = result_step_q;
  assign o_result_peak  = result_peak_q;
  assign o_result_last  = result_last_q;

endmodule

// File: tb/tb_sweep_controller.sv
// Self-checking bench for sweep_controller: timeline model of the sweep plus
// directed scenarios with literal expectations.
module tb_sweep_controller;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               i_start = 1'b0;
  logic               i_abort = 1'b0;
  logic [31:0]        i_start_step = 32'd0;
  logic [31:0]        i_stop_step = 32'd0;
  logic [31:0]        i_step_inc = 32'd0;
  logic [23:0]        i_settle = 24'd0;
  logic [23:0]        i_dwell = 24'd0;
  logic signed [23:0] i_filt_data = 24'sd0;
  logic [31:0]        o_phase_step;
  logic               o_gen_rst, o_busy, o_done, o_result_valid, o_result_last;
  logic [31:0]        o_result_step;
  logic [23:0]        o_result_peak;

  sweep_controller dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_start         (i_start),
    .i_abort         (i_abort),
    .i_start_step    (i_start_step),
    .i_stop_step     (i_stop_step),
    .i_step_inc      (i_step_inc),
    .i_settle_cycles (i_settle),
    .i_dwell_cycles  (i_dwell),
    .i_filt_data     (i_filt_data),
    .o_phase_step    (o_phase_step),
    .o_gen_rst       (o_gen_rst),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_result_valid  (o_result_valid),
    .o_result_step   (o_result_step),
    .o_result_peak   (o_result_peak),
    .o_result_last   (o_result_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] phase;
    logic [31:0] rstep;
    logic [23:0] rpeak;
    bit busy, gen, done, valid, last;
  } exp_t;

  typedef struct {
    int          t;
    logic [31:0] step;
    logic [23:0] peak;
    bit          last;
  } res_t;

  int          total = 0, bad = 0;
  int          edge_n = 0;
  int          data_log [0:16383];
  int          e0 = 0, ta = 1 << 30;
  bit          in_sweep = 1'b0;
  longint      cfg_stop, cfg_inc;
  int          cfg_s = 0, cfg_d = 0;
  longint      pts [0:15];
  int          npts = 0;
  logic [31:0] prev_phase = 32'd0, prev_rstep = 32'd0;
  logic [23:0] prev_rpeak = 24'd0;
  res_t        vq[$];
  int          done_t = -1;
  int          data_mode = 0, const_val = 0;

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Record the filter sample seen at every rising edge.
  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    data_log[(edge_n + 1) & 16383] <= int'(i_filt_data);
  end

  function automatic longint peak_of(int last_edge, int n);
    longint m, v;
    m = 0;
    for (int i = 0; i < n; i++) begin
      v = data_log[(last_edge - i) & 16383];
      if (v < 0) v = -v;
      if (v > m) m = v;
    end
    return m;
  endfunction

  // Expected outputs after edge E(t) of the current sweep (t counted from E0).
  function automatic exp_t model(int t);
    exp_t e;
    int de, p, te, nr, ph, r, rl;
    e.phase = prev_phase; e.rstep = prev_rstep; e.rpeak = prev_rpeak;
    e.busy = 0; e.gen = 0; e.done = 0; e.valid = 0; e.last = 0;
    if (in_sweep && t >= 0) begin
      de = (cfg_d == 0) ? 1 : cfg_d;
      p  = cfg_s + de + 1;
      te = (t < ta) ? t : ta - 1;
      nr = 0; ph = 0;
      for (int k = 0; k < npts; k++) begin
        r = 2 + cfg_s + de + k * p;
        if (r <= te) nr = k + 1;
        if (r < te && k < npts - 1) ph = k + 1;
        if (t < ta && r == t) begin
          e.valid = 1;
          e.last  = (k == npts - 1);
        end
      end
      e.phase = 32'(pts[ph]);
      if (nr > 0) begin
        e.rstep = 32'(pts[nr - 1]);
        e.rpeak = 24'(peak_of(e0 + 2 + cfg_s + de + (nr - 1) * p, de));
      end
      rl = 2 + cfg_s + de + (npts - 1) * p;
      if (t < ta) begin
        e.gen  = (t <= 1);
        e.done = (t == rl + 1);
        e.busy = (t <= rl + 1);
      end
    end
    return e;
  endfunction

  // Every-cycle comparison against the model, plus result/done capture.
  always @(negedge clk) begin
    exp_t e;
    int t;
    t = edge_n - e0;
    e = model(t);
    chk("busy", o_busy, e.busy);
    chk("gen_rst", o_gen_rst, e.gen);
    chk("done", o_done, e.done);
    chk("valid", o_result_valid, e.valid);
    chk("last", o_result_last, e.last);
    chk("phase", o_phase_step, e.phase);
    chk("rstep", o_result_step, e.rstep);
    chk("rpeak", o_result_peak, e.rpeak);
    if (o_result_valid) vq.push_back('{t, o_result_step, o_result_peak, o_result_last});
    if (o_done) done_t = t;
  end

  task automatic tick();
    int v;
    @(negedge clk);
    if (data_mode == 0) begin
      v = const_val;
    end else begin
      v = (edge_n * 37) % 1000;
      if (edge_n % 2 == 1) v = -v;
    end
    i_filt_data = 24'(v);
  endtask

  task automatic launch(longint st, longint sp, longint inc, int s, int d);
    exp_t   cur;
    longint x;
    cur = model(edge_n - e0);
    prev_phase = cur.phase; prev_rstep = cur.rstep; prev_rpeak = cur.rpeak;
    cfg_stop = sp; cfg_inc = inc; cfg_s = s; cfg_d = d;
    npts = 0; x = st;
    while (1) begin
      pts[npts] = x;
      npts++;
      if (inc == 0 || x + inc > sp || npts == 16) break;
      x += inc;
    end
    e0 = edge_n + 1; ta = 1 << 30; in_sweep = 1'b1; vq.delete(); done_t = -1;
    i_start_step = 32'(st); i_stop_step = 32'(sp); i_step_inc = 32'(inc);
    i_settle = 24'(s); i_dwell = 24'(d); i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_start_step = 32'h0000_0BAD; i_stop_step = 32'd0; i_step_inc = 32'd1;
    i_settle = 24'd1; i_dwell = 24'd1;
  endtask

  task automatic wait_idle(string name);
    int n;
    n = 0;
    while (o_busy && n < 3000) begin
      tick();
      n++;
    end
    chk({name, "_timeout"}, longint'(n < 3000), 1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    longint a_steps [0:2];
    a_steps = '{100, 200, 300};

    repeat (3) tick();
    chk("rst_busy", o_busy, 0);
    chk("rst_phase", o_phase_step, 0);
    chk("rst_rpeak", o_result_peak, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Basic three-point sweep; a start pulse mid-sweep must be ignored.
    data_mode = 0; const_val = -500;
    launch(100, 300, 100, 4, 8);
    repeat (5) tick();
    i_start = 1'b1; i_start_step = 32'd7;
    tick();
    i_start = 1'b0;
    wait_idle("A");
    chk("A_count", vq.size(), 3);
    for (int i = 0; i < vq.size() && i < 3; i++) begin
      chk("A_step", vq[i].step, a_steps[i]);
      chk("A_peak", vq[i].peak, 500);
      chk("A_t", vq[i].t, 14 + 13 * i);
      chk("A_last", vq[i].last, (i == 2) ? 1 : 0);
    end
    chk("A_done_t", done_t, 41);

    // Most negative sample.
    const_val = -8388608;
    launch(7, 7, 1, 2, 3);
    wait_idle("B");
    chk("B_count", vq.size(), 1);
    if (vq.size() > 0) begin
      chk("B_peak", vq[0].peak, 8388608);
      chk("B_t", vq[0].t, 7);
      chk("B_last", vq[0].last, 1);
    end

    // inc=0 with zero settle and zero dwell.
    const_val = 1234;
    launch(500, 1000, 0, 0, 0);
    wait_idle("C");
    chk("C_count", vq.size(), 1);
    if (vq.size() > 0) begin
      chk("C_step", vq[0].step, 500);
      chk("C_t", vq[0].t, 3);
      chk("C_peak", vq[0].peak, 1234);
    end
    chk("C_done_t", done_t, 4);

    // start > stop.
    const_val = -7;
    launch(500, 200, 10, 1, 2);
    wait_idle("D");
    chk("D_count", vq.size(), 1);
    if (vq.size() > 0) begin
      chk("D_step", vq[0].step, 500);
      chk("D_last", vq[0].last, 1);
    end

    // Carry out of the phase range ends the sweep.
    const_val = 3;
    launch(64'hFFFF_FF00, 64'hFFFF_FFF0, 64'h80, 1, 1);
    wait_idle("E");
    chk("E_count", vq.size(), 2);
    if (vq.size() > 1) begin
      chk("E_step1", vq[1].step, 64'hFFFF_FF80);
      chk("E_last1", vq[1].last, 1);
      chk("E_last0", vq[0].last, 0);
    end
    chk("E_phase", o_phase_step, 64'hFFFF_FF80);

    // Abort during the second dwell, then a fresh full sweep.
    data_mode = 1;
    launch(100, 300, 100, 4, 8);
    repeat (21) tick();
    i_abort = 1'b1; ta = edge_n + 1 - e0;
    tick();
    i_abort = 1'b0;
    chk("F_busy", o_busy, 0);
    chk("F_phase", o_phase_step, 200);
    repeat (5) tick();
    chk("F_count", vq.size(), 1);
    chk("F_done_t", done_t, -1);
    launch(100, 300, 100, 4, 8);
    wait_idle("F2");
    chk("F2_count", vq.size(), 3);

    // Start together with abort in IDLE is ignored.
    i_start = 1'b1; i_abort = 1'b1; i_start_step = 32'd55;
    tick();
    i_start = 1'b0; i_abort = 1'b0;
    repeat (3) tick();
    chk("G_busy", o_busy, 0);

    // Asynchronous reset in the middle of SETTLE.
    data_mode = 0; const_val = 99;
    launch(1000, 5000, 1000, 10, 4);
    repeat (5) tick();
    #2;
    rst_n = 1'b0; in_sweep = 1'b0;
    prev_phase = 32'd0; prev_rstep = 32'd0; prev_rpeak = 24'd0;
    #1;
    chk("H_busy", o_busy, 0);
    chk("H_phase", o_phase_step, 0);
    chk("H_rstep", o_result_step, 0);
    chk("H_gen_rst", o_gen_rst, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    launch(1000, 3000, 1000, 0, 2);
    wait_idle("H2");
    chk("H2_count", vq.size(), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
